lcd_status_sequencer: RTL and testbench



---
 rtl/lcd_status_sequencer_if.sv | 21 ++
 rtl/lcd_status_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lcd_status_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_status_sequencer_if.sv
// Host-side handshake of LCD_Controller: one byte per start/done exchange.
interface lcd_status_sequencer_if;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       iLCD_DONE;

  modport master (
    output oLCD_DATA,
    output oLCD_RS,
    output oLCD_START,
    input  iLCD_DONE
  );

  modport slave (
    input  oLCD_DATA,
    input  oLCD_RS,
    input  oLCD_START,
    output iLCD_DONE
  );
endinterface

// File: rtl/lcd_status_sequencer.sv
// LCD status sequencer: runs the LCD init commands after reset, then repaints line 1
// (movement text) when iMOVE changes and line 2 (floor number) when iFLOOR changes.
module lcd_status_sequencer #(
  parameter int unsigned DLY_CYCLES = 262142,
  parameter int unsigned DLY_W      = 18
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [1:0]             iMOVE,
  input  logic [3:0]             iFLOOR,
  output logic                   oBUSY,
  lcd_status_sequencer_if.master lcd
);

  typedef enum logic [2:0] {StLoad, StWait, StDelay, StNext, StIdle} state_e;
  typedef enum logic [1:0] {SeqInit, SeqLine1, SeqLine2} seq_e;

  localparam logic [DLY_W-1:0] DlyLast = DLY_W'(DLY_CYCLES - 1);

  // 16-character line images, first character in the top byte.
  localparam logic [127:0] TxtParado   = {"Parado", {10{8'h20}}};
  localparam logic [127:0] TxtSubindo  = {"Subindo", {9{8'h20}}};
  localparam logic [127:0] TxtDescendo = {"Descendo", {8{8'h20}}};
  localparam logic [127:0] TxtErro     = {"Erro", {12{8'h20}}};
  localparam logic [127:0] TxtAndar    = {"Andar ", 8'h3F, {9{8'h20}}};

  state_e           stateQ, stateD;
  seq_e             seqQ, seqD;
  logic [4:0]       idxQ, idxD;
  logic [DLY_W-1:0] cntQ, cntD;
  logic [7:0]       dataQ, dataD;
  logic             rsQ, rsD;
  logic             startQ, startD;
  logic             busyQ, busyD;
  logic [1:0]       shownMoveQ, shownMoveD;
  logic [3:0]       shownFloorQ, shownFloorD;
  logic             valid1Q, valid1D;
  logic             valid2Q, valid2D;

  logic [3:0]   pos;
  logic [127:0] lineText;
  logic [7:0]   curByte;
  logic [4:0]   lastIdx;
  logic         dirty1, dirty2, launch;

  // Byte for the current index, derived only from the snapshot registers.
  always_comb begin
    pos      = 4'(idxQ - 5'd1);
    lineText = TxtParado;
    curByte  = 8'h20;
    case (seqQ)
      SeqInit: begin
        case (idxQ[1:0])
          2'd0:    curByte = 8'h38;
          2'd1:    curByte = 8'h0C;
          2'd2:    curByte = 8'h01;
          default: curByte = 8'h06;
        endcase
      end
      SeqLine1: begin
        case (shownMoveQ)
          2'd0:    lineText = TxtParado;
          2'd1:    lineText = TxtSubindo;
          2'd2:    lineText = TxtDescendo;
          default: lineText = TxtErro;
        endcase
        curByte = (idxQ == 5'd0) ? 8'h80 : lineText[{~pos, 3'b000} +: 8];
      end
      default: begin
        if (idxQ == 5'd0) begin
          curByte = 8'hC0;
        end else if (pos == 4'd6) begin
          curByte = (shownFloorQ <= 4'd9) ? (8'h30 + {4'h0, shownFloorQ}) : 8'h3F;
        end else begin
          curByte = TxtAndar[{~pos, 3'b000} +: 8];
        end
      end
    endcase
  end

  // Write-primitive FSM plus line scheduling; a finished sequence chains straight into
  // the next dirty line so oBUSY never dips between back-to-back refreshes.
  always_comb begin
    stateD      = stateQ;
    seqD        = seqQ;
    idxD        = idxQ;
    cntD        = cntQ;
    dataD       = dataQ;
    rsD         = rsQ;
    startD      = startQ;
    busyD       = busyQ;
    shownMoveD  = shownMoveQ;
    shownFloorD = shownFloorQ;
    valid1D     = valid1Q;
    valid2D     = valid2Q;
    launch      = 1'b0;
    lastIdx     = (seqQ == SeqInit) ? 5'd3 : 5'd16;
    dirty1      = !valid1Q || (iMOVE != shownMoveQ);
    dirty2      = !valid2Q || (iFLOOR != shownFloorQ);

    case (stateQ)
      StLoad: begin
        dataD  = curByte;
        rsD    = (seqQ != SeqInit) && (idxQ != 5'd0);
        startD = 1'b1;
        stateD = StWait;
      end
      StWait: begin
        if (lcd.iLCD_DONE) begin
          startD = 1'b0;
          cntD   = '0;
          stateD = StDelay;
        end
      end
      StDelay: begin
        if (cntQ == DlyLast) begin
          stateD = StNext;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StNext: begin
        if (idxQ != lastIdx) begin
          idxD   = idxQ + 5'd1;
          stateD = StLoad;
        end else begin
          launch = 1'b1;
        end
      end
      default: launch = 1'b1;
    endcase

    if (launch) begin
      idxD = 5'd0;
      if (dirty1) begin
        seqD       = SeqLine1;
        shownMoveD = iMOVE;
        valid1D    = 1'b1;
        busyD      = 1'b1;
        stateD     = StLoad;
      end else if (dirty2) begin
        seqD        = SeqLine2;
        shownFloorD = iFLOOR;
        valid2D     = 1'b1;
        busyD       = 1'b1;
        stateD      = StLoad;
      end else begin
        busyD  = 1'b0;
        stateD = StIdle;
      end
    end
  end

  // State register; reset restarts the init sequence and drops start at once.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ      <= StLoad;
      seqQ        <= SeqInit;
      idxQ        <= 5'd0;
      cntQ        <= '0;
      dataQ       <= 8'h00;
      rsQ         <= 1'b0;
      startQ      <= 1'b0;
      busyQ       <= 1'b1;
      shownMoveQ  <= 2'd0;
      shownFloorQ <= 4'd0;
      valid1Q     <= 1'b0;
      valid2Q     <= 1'b0;
    end else begin
      stateQ      <= stateD;
      seqQ        <= seqD;
      idxQ        <= idxD;
      cntQ        <= cntD;
      dataQ       <= dataD;
      rsQ         <= rsD;
      startQ      <= startD;
      busyQ       <= busyD;
      shownMoveQ  <= shownMoveD;
      shownFloorQ <= shownFloorD;
      valid1Q     <= valid1D;
      valid2Q     <= valid2D;
    end
  end

  assign lcd.oLCD_DATA  = dataQ;
  assign lcd.oLCD_RS    = rsQ;
  assign lcd.oLCD_START = startQ;
  assign oBUSY          = busyQ;

endmodule

// File: tb/tb_lcd_status_sequencer.sv
// Bench for lcd_status_sequencer with a short settle delay and a simple LCD_Controller model.
module tb_lcd_status_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] move = 2'd0;
  logic [3:0] floor = 4'd0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  lcd_status_sequencer_if lcdBus();

  lcd_status_sequencer #(
    .DLY_CYCLES(4),
    .DLY_W     (3)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rstN),
    .iMOVE (move),
    .iFLOOR(floor),
    .oBUSY (busy),
    .lcd   (lcdBus)
  );

  always #5 clk = ~clk;

  // Controller model: done pulses doneDelay cycles after start rises; logs every write.
  int         doneDelay = 3;
  int         cnt = 0;
  logic       startPrev = 1'b0;
  logic [8:0] wlog [0:511];
  int         wcnt = 0;

  always @(posedge clk) begin
    if (!rstN) begin
      startPrev        <= 1'b0;
      cnt              <= 0;
      lcdBus.iLCD_DONE <= 1'b0;
    end else begin
      startPrev        <= lcdBus.oLCD_START;
      lcdBus.iLCD_DONE <= 1'b0;
      if (lcdBus.oLCD_START && !startPrev) begin
        wlog[wcnt] <= {lcdBus.oLCD_RS, lcdBus.oLCD_DATA};
        wcnt       <= wcnt + 1;
        cnt        <= 1;
      end else if (cnt != 0) begin
        if (cnt == doneDelay - 1) begin
          lcdBus.iLCD_DONE <= 1'b1;
          cnt              <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Expected write i of a line refresh: address command, then text padded with spaces.
  function automatic logic [8:0] expWrite(input bit line2, input string txt, input int i);
    if (i == 0) return {1'b0, (line2 ? 8'hC0 : 8'h80)};
    if (i - 1 < txt.len()) return {1'b1, txt.getc(i - 1)};
    return {1'b1, 8'h20};
  endfunction

  task automatic waitBusy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== lvl) begin
      failures++;
      $display("FAIL %s: oBUSY=%b after %0d cycles, want %b", tag, busy, n, lvl);
    end
  endtask

  task automatic waitWrites(input int target, input int budget, input string tag);
    int n = 0;
    while (wcnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wcnt < target) begin
      failures++;
      $display("FAIL %s: writes=%0d, want at least %0d", tag, wcnt, target);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (lcdBus.oLCD_START !== 1'b0) begin
      failures++; $display("FAIL reset start: got %b want 0", lcdBus.oLCD_START);
    end
    if (lcdBus.oLCD_DATA !== 8'h00) begin
      failures++; $display("FAIL reset data: got %h want 00", lcdBus.oLCD_DATA);
    end
    if (lcdBus.oLCD_RS !== 1'b0) begin
      failures++; $display("FAIL reset rs: got %b want 0", lcdBus.oLCD_RS);
    end
    if (busy !== 1'b1) begin
      failures++; $display("FAIL reset busy: got %b want 1", busy);
    end
    rstN = 1'b1;
  endtask

  task automatic test_init();
    logic [7:0] cmds [0:3] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int base = wcnt;
    waitBusy(1'b0, 3000, "init idle");
    checks++;
    if (wcnt - base != 38) begin
      failures++; $display("FAIL init count: got %0d want 38", wcnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wlog[base + i] !== {1'b0, cmds[i]}) begin
        failures++; $display("FAIL init cmd %0d: got %h want %h", i, wlog[base + i], {1'b0, cmds[i]});
      end
    end
    for (int i = 0; i < 17; i++) begin
      checks += 2;
      if (wlog[base + 4 + i] !== expWrite(1'b0, "Parado", i)) begin
        failures++;
        $display("FAIL init line1 %0d: got %h want %h", i, wlog[base + 4 + i], expWrite(1'b0, "Parado", i));
      end
      if (wlog[base + 21 + i] !== expWrite(1'b1, "Andar 0", i)) begin
        failures++;
        $display("FAIL init line2 %0d: got %h want %h", i, wlog[base + 21 + i], expWrite(1'b1, "Andar 0", i));
      end
    end
  endtask

  task automatic test_move();
    int base = wcnt;
    move = 2'd1;
    waitBusy(1'b1, 20, "move start");
    waitBusy(1'b0, 1000, "move idle");
    checks++;
    if (wcnt - base != 17) begin
      failures++; $display("FAIL move count: got %0d want 17", wcnt - base);
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (wlog[base + i] !== expWrite(1'b0, "Subindo", i)) begin
        failures++;
        $display("FAIL move byte %0d: got %h want %h", i, wlog[base + i], expWrite(1'b0, "Subindo", i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int base = wcnt;
    move  = 2'd2;
    floor = 4'd3;
    waitBusy(1'b1, 20, "both start");
    waitBusy(1'b0, 2000, "both idle");
    checks++;
    if (wcnt - base != 34) begin
      failures++; $display("FAIL both count (busy dipped or extra writes): got %0d want 34", wcnt - base);
    end
    for (int i = 0; i < 17; i++) begin
      checks += 2;
      if (wlog[base + i] !== expWrite(1'b0, "Descendo", i)) begin
        failures++;
        $display("FAIL both line1 %0d: got %h want %h", i, wlog[base + i], expWrite(1'b0, "Descendo", i));
      end
      if (wlog[base + 17 + i] !== expWrite(1'b1, "Andar 3", i)) begin
        failures++;
        $display("FAIL both line2 %0d: got %h want %h", i, wlog[base + 17 + i], expWrite(1'b1, "Andar 3", i));
      end
    end
  endtask

  task automatic test_floor_unknown();
    int base = wcnt;
    floor = 4'd12;
    waitBusy(1'b1, 20, "floor12 start");
    waitBusy(1'b0, 1000, "floor12 idle");
    checks += 2;
    if (wcnt - base != 17) begin
      failures++; $display("FAIL floor12 count: got %0d want 17", wcnt - base);
    end
    if (wlog[base + 7] !== 9'h13F) begin
      failures++; $display("FAIL floor12 digit: got %h want 13f", wlog[base + 7]);
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (wlog[base + i] !== expWrite(1'b1, "Andar ?", i)) begin
        failures++;
        $display("FAIL floor12 byte %0d: got %h want %h", i, wlog[base + i], expWrite(1'b1, "Andar ?", i));
      end
    end
  endtask

  task automatic test_floor_mid_refresh();
    int base = wcnt;
    floor = 4'd3;
    waitBusy(1'b1, 20, "mid start");
    waitWrites(base + 6, 500, "mid byte5");
    floor = 4'd4;
    repeat (3) @(negedge clk);
    floor = 4'd5;
    waitBusy(1'b0, 2000, "mid idle");
    checks++;
    if (wcnt - base != 34) begin
      failures++; $display("FAIL mid count: got %0d want 34", wcnt - base);
    end
    for (int i = 0; i < 17; i++) begin
      checks += 2;
      if (wlog[base + i] !== expWrite(1'b1, "Andar 3", i)) begin
        failures++;
        $display("FAIL mid first %0d: got %h want %h", i, wlog[base + i], expWrite(1'b1, "Andar 3", i));
      end
      if (wlog[base + 17 + i] !== expWrite(1'b1, "Andar 5", i)) begin
        failures++;
        $display("FAIL mid second %0d: got %h want %h", i, wlog[base + 17 + i], expWrite(1'b1, "Andar 5", i));
      end
    end
  endtask

  task automatic test_handshake();
    int         base = wcnt;
    int         k = 0;
    int         n = 0;
    bit         stable = 1'b1;
    logic [7:0] d0;
    logic       r0;
    doneDelay = 20;
    move = 2'd3;
    while (lcdBus.oLCD_START !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    d0 = lcdBus.oLCD_DATA;
    r0 = lcdBus.oLCD_RS;
    checks += 2;
    if ({r0, d0} !== 9'h080) begin
      failures++; $display("FAIL hs first write: got %h want 080", {r0, d0});
    end
    while (lcdBus.iLCD_DONE !== 1'b1 && k < 100) begin
      if (lcdBus.oLCD_START !== 1'b1 || lcdBus.oLCD_DATA !== d0 || lcdBus.oLCD_RS !== r0) stable = 1'b0;
      k++;
      @(negedge clk);
    end
    if (k != 20 || !stable) begin
      failures++; $display("FAIL hs hold: cycles=%0d stable=%b want 20 stable=1", k, stable);
    end
    checks += 3;
    if (lcdBus.oLCD_START !== 1'b1) begin
      failures++; $display("FAIL hs start at done: got %b want 1", lcdBus.oLCD_START);
    end
    @(negedge clk);
    if (lcdBus.oLCD_START !== 1'b0) begin
      failures++; $display("FAIL hs start after done: got %b want 0", lcdBus.oLCD_START);
    end
    n = 0;
    while (lcdBus.oLCD_START !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n != 6) begin
      failures++; $display("FAIL hs restart gap: got %0d want 6", n);
    end
    doneDelay = 3;
    waitBusy(1'b0, 1000, "hs idle");
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (wlog[base + i] !== expWrite(1'b0, "Erro", i)) begin
        failures++;
        $display("FAIL hs byte %0d: got %h want %h", i, wlog[base + i], expWrite(1'b0, "Erro", i));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int base = wcnt;
    int n = 0;
    floor = 4'd6;
    waitBusy(1'b1, 20, "rst start");
    waitWrites(base + 3, 500, "rst byte2");
    while (lcdBus.oLCD_START !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rstN = 1'b0;
    #1;
    checks += 3;
    if (lcdBus.oLCD_START !== 1'b0) begin
      failures++; $display("FAIL rst async start: got %b want 0", lcdBus.oLCD_START);
    end
    if (lcdBus.oLCD_DATA !== 8'h00) begin
      failures++; $display("FAIL rst async data: got %h want 00", lcdBus.oLCD_DATA);
    end
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rst async busy: got %b want 1", busy);
    end
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    base = wcnt;
    waitWrites(base + 1, 100, "rst first write");
    checks++;
    if (wlog[base] !== 9'h038) begin
      failures++; $display("FAIL rst first byte: got %h want 038", wlog[base]);
    end
    waitBusy(1'b0, 3000, "rst idle");
    checks++;
    if (wcnt - base != 38) begin
      failures++; $display("FAIL rst count: got %0d want 38", wcnt - base);
    end
    for (int i = 0; i < 17; i++) begin
      checks += 2;
      if (wlog[base + 4 + i] !== expWrite(1'b0, "Erro", i)) begin
        failures++;
        $display("FAIL rst line1 %0d: got %h want %h", i, wlog[base + 4 + i], expWrite(1'b0, "Erro", i));
      end
      if (wlog[base + 21 + i] !== expWrite(1'b1, "Andar 6", i)) begin
        failures++;
        $display("FAIL rst line2 %0d: got %h want %h", i, wlog[base + 21 + i], expWrite(1'b1, "Andar 6", i));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_move();
    test_back_to_back();
    test_floor_unknown();
    test_floor_mid_refresh();
    test_handshake();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
